stimulus_sequencer: RTL and testbench
=====================================

// Module: stimulus_sequencer
// PURPOSE
//  Synthesizable, parametrised replacement for the fixed single-entry concolic stimulus driver.
//  Replays a loaded table of input vectors into the DUT's primary inputs plus the __obs observation flag.
//  Each entry can be held for several cycles, and the table runs one-shot or looped.
//  Sits between the concolic harness (loads vectors, starts runs) and the DUT input ports.
// PARAMETERS
//  NUM_LINES  2   number of DUT input lines driven (line1..lineN)
//  DEPTH      16  vector table entries
//  ADDR_W     $clog2(DEPTH)  table address width
//  REP_W      4   per-entry hold-count width
//  WORD_W     REP_W+1+NUM_LINES  entry layout {rep[REP_W-1:0], obs, lines[NUM_LINES-1:0]}
// PORTS
//  clock      in   1          rising-edge clock
//  reset      in   1          asynchronous, active-high reset
//  load_en    in   1          write strobe for one table entry
//  load_addr  in   ADDR_W     table write address
//  load_data  in   WORD_W     table write data
//  load_err   out  1          one-cycle pulse: write rejected because a run is active
//  last_addr  in   ADDR_W     final entry of the program (sampled at start)
//  loop_mode  in   1          1 = wrap to entry 0 after last_addr (sampled at start)
//  start      in   1          begin a run from entry 0
//  stop       in   1          abort the run
//  lines      out  NUM_LINES  stimulus to the DUT input lines
//  obs        out  1          stimulus to the DUT __obs input
//  busy       out  1          high in RUN
//  done       out  1          high in DONE (one-shot run completed)
//  pc         out  ADDR_W     address of the entry currently driven
//  step_cnt   out  32         cycles applied in the current or last run; saturates at 2^32-1
// BEHAVIOUR
//  Reset (asynchronous): state=IDLE; all outputs 0; table contents undefined (not cleared).
//  FSM IDLE/RUN/DONE; every output is registered.
//   IDLE -> RUN   on start & !stop
//                 latches last_addr and loop_mode; pc=0; step_cnt=0
//                 entry 0 appears on lines/obs the cycle after start is sampled (latency 1)
//   RUN:          entry held rep+1 cycles (rep=0 gives 1 cycle; rep=2^REP_W-1 gives 2^REP_W cycles)
//                 step_cnt increments on every RUN cycle
//                 after the final hold cycle of entry pc:
//                   pc<last_addr                -> pc+1
//                   pc==last_addr & loop_mode   -> pc=0, stay in RUN
//                   pc==last_addr & !loop_mode  -> DONE
//   RUN -> IDLE   on stop; lines/obs/pc return to 0 the next cycle; step_cnt holds
//   DONE:         lines/obs=0; done=1; step_cnt holds
//                 start -> RUN (same as from IDLE); stop -> IDLE
//  Simultaneous start and stop: stop wins; no run begins.
//  start while in RUN is ignored.
//  last_addr >= DEPTH is clamped to DEPTH-1 at start.
//  Table writes are accepted in IDLE or DONE; the entry is readable one cycle after load_en.
//  A write in RUN is dropped, and load_err pulses high for exactly one cycle.
//  Any write in the same cycle start is sampled completes before entry 0 is fetched.
//  Reset asserted mid-run forces IDLE at once; outputs are 0 while reset is high.
// STRUCTURE
//  Package stim_pkg:
//   state enum {ST_IDLE, ST_RUN, ST_DONE}
//   entry field offset/width localparams; function to unpack an entry
//  Sub-module stim_vector_ram:
//   DEPTH x WORD_W, one write port, asynchronous read port
//   read is combinational so the FSM meets the 1-cycle latency
//  Top level: FSM, hold-down counter (REP_W bits), pc register, step counter, output registers.
// TESTING
//  T1 reset: assert reset mid-run at an arbitrary phase
//     -> lines/obs/busy/done/pc all 0 asynchronously; IDLE after release
//  T2 one-shot, NUM_LINES=2
//     table {rep0,obs0,2'b01},{rep2,obs1,2'b10},{rep0,obs0,2'b11}; last_addr=2; start
//     -> lines 01 x1, 10 x3 (obs=1), 11 x1; then done=1, step_cnt=5
//  T3 loop: same table, loop_mode=1, stop after 12 cycles
//     -> pattern period 5, pc wraps 2->0; outputs 0 and busy=0 one cycle after stop
//  T4 write in RUN: load_en during RUN -> load_err one-cycle pulse; later replay shows the old entry
//  T5 simultaneous start and stop in IDLE -> stays IDLE; busy stays 0
//  T6 max hold: rep=4'hF, last_addr=0, one-shot -> entry held 16 cycles, then DONE, step_cnt=16

Source files
------------

// File: rtl/stim_pkg.sv
// Shared state encoding and table-entry layout helpers for the stimulus sequencer.
// An entry is packed as {rep, obs, lines}, with lines starting at bit 0.
package stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int LINES_LSB  = 0;
    localparam int OBS_W      = 1;
    localparam int MAX_WORD_W = 64;

    typedef logic [MAX_WORD_W-1:0] word_t;

    // Extracts a field of the given width starting at bit lsb.
    function automatic word_t entry_field(input word_t word, input int lsb, input int width);
        word_t mask;
        mask = (width >= MAX_WORD_W) ? '1 : ((word_t'(1) << width) - word_t'(1));
        return (word >> lsb) & mask;
    endfunction

endpackage

// File: rtl/stim_vector_ram.sv
// Vector table storage: one synchronous write port and one combinational read port.
// The combinational read lets the sequencer fetch and register an entry in a single cycle.
module stim_vector_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int WORD_W = 7
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Contents are intentionally never reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stimulus_sequencer.sv
// Replays a loaded table of input vectors onto the DUT lines and __obs flag,
// holding each entry rep+1 cycles, one-shot or looped.
module stimulus_sequencer
    import stim_pkg::*;
#(
    parameter int NUM_LINES = 2,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int REP_W     = 4,
    parameter int WORD_W    = REP_W + 1 + NUM_LINES
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_en,
    input  logic [ADDR_W-1:0]    load_addr,
    input  logic [WORD_W-1:0]    load_data,
    output logic                 load_err,
    input  logic [ADDR_W-1:0]    last_addr,
    input  logic                 loop_mode,
    input  logic                 start,
    input  logic                 stop,
    output logic [NUM_LINES-1:0] lines,
    output logic                 obs,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    pc,
    output logic [31:0]          step_cnt
);

    localparam int OBS_LSB = LINES_LSB + NUM_LINES;
    localparam int REP_LSB = OBS_LSB + OBS_W;
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH - 1);

    state_t                 state;
    logic [ADDR_W-1:0]      last_q;
    logic                   loop_q;
    logic [REP_W-1:0]       hold_cnt;

    logic                   wr_ok;
    logic [ADDR_W-1:0]      nxt_pc;
    logic [ADDR_W-1:0]      rd_addr;
    logic [ADDR_W-1:0]      start_last;
    logic [WORD_W-1:0]      ram_word;
    logic [WORD_W-1:0]      fetch_word;
    logic [NUM_LINES-1:0]   fetch_lines;
    logic                   fetch_obs;
    logic [REP_W-1:0]       fetch_rep;

    assign wr_ok      = load_en && (state != ST_RUN) && (32'(load_addr) < 32'(DEPTH));
    assign nxt_pc     = (pc == last_q) ? '0 : pc + 1'b1;
    assign rd_addr    = (state == ST_RUN) ? nxt_pc : '0;
    assign start_last = (32'(last_addr) > 32'(DEPTH - 1)) ? MAX_ADDR : last_addr;

    stim_vector_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_ok),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_addr (rd_addr),
        .rd_data (ram_word)
    );

    // A write landing in the same cycle as start must be seen by the entry-0 fetch.
    assign fetch_word  = (wr_ok && (load_addr == rd_addr)) ? load_data : ram_word;
    assign fetch_lines = NUM_LINES'(entry_field(word_t'(fetch_word), LINES_LSB, NUM_LINES));
    assign fetch_obs   = entry_field(word_t'(fetch_word), OBS_LSB, OBS_W) != '0;
    assign fetch_rep   = REP_W'(entry_field(word_t'(fetch_word), REP_LSB, REP_W));

    // ---- sequencer state and registered outputs ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            last_q   <= '0;
            loop_q   <= 1'b0;
            hold_cnt <= '0;
            pc       <= '0;
            step_cnt <= '0;
            lines    <= '0;
            obs      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            load_err <= load_en && (state == ST_RUN);
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start && !stop) begin
                        state    <= ST_RUN;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        last_q   <= start_last;
                        loop_q   <= loop_mode;
                        pc       <= '0;
                        step_cnt <= '0;
                        lines    <= fetch_lines;
                        obs      <= fetch_obs;
                        hold_cnt <= fetch_rep;
                    end else if (stop) begin
                        state <= ST_IDLE;
                        done  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (step_cnt != '1) begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                    if (stop) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        pc       <= '0;
                        lines    <= '0;
                        obs      <= 1'b0;
                        hold_cnt <= '0;
                    end else if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end else if ((pc == last_q) && !loop_q) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pc    <= '0;
                        lines <= '0;
                        obs   <= 1'b0;
                    end else begin
                        pc       <= nxt_pc;
                        lines    <= fetch_lines;
                        obs      <= fetch_obs;
                        hold_cnt <= fetch_rep;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stimulus_sequencer.sv
// Directed bench for stimulus_sequencer: one-shot, loop, rejected writes,
// start/stop collision, maximum hold and asynchronous reset mid-run.
module tb_stimulus_sequencer;

    localparam int NUM_LINES = 2;
    localparam int DEPTH     = 16;
    localparam int ADDR_W    = 4;
    localparam int REP_W     = 4;
    localparam int WORD_W    = 7;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 load_en = 1'b0;
    logic [ADDR_W-1:0]    load_addr = '0;
    logic [WORD_W-1:0]    load_data = '0;
    logic                 load_err;
    logic [ADDR_W-1:0]    last_addr = '0;
    logic                 loop_mode = 1'b0;
    logic                 start = 1'b0;
    logic                 stop = 1'b0;
    logic [NUM_LINES-1:0] lines;
    logic                 obs;
    logic                 busy;
    logic                 done;
    logic [ADDR_W-1:0]    pc;
    logic [31:0]          step_cnt;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle pattern of the three-entry program {01 x1, 10 x3 obs, 11 x1}.
    logic [1:0] pat_lines [5] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b11};
    logic       pat_obs   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] pat_pc    [5] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2};

    always #5 clock = ~clock;

    stimulus_sequencer #(
        .NUM_LINES (NUM_LINES),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .REP_W     (REP_W),
        .WORD_W    (WORD_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .load_err  (load_err),
        .last_addr (last_addr),
        .loop_mode (loop_mode),
        .start     (start),
        .stop      (stop),
        .lines     (lines),
        .obs       (obs),
        .busy      (busy),
        .done      (done),
        .pc        (pc),
        .step_cnt  (step_cnt)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic begin_run(input logic [ADDR_W-1:0] la, input logic lm);
        last_addr = la;
        loop_mode = lm;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        chk("rst_lines", 32'(lines), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_step", step_cnt, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Table: {rep0,obs0,01}, {rep2,obs1,10}, {rep0,obs0,11}
        load(4'd0, 7'h01);
        load(4'd1, 7'h16);
        load(4'd2, 7'h03);

        // T2 one-shot
        begin_run(4'd2, 1'b0);
        chk("t2_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            chk("t2_lines", 32'(lines), 32'(pat_lines[i]));
            chk("t2_obs", 32'(obs), 32'(pat_obs[i]));
            chk("t2_pc", 32'(pc), 32'(pat_pc[i]));
        end
        tick();
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_busy_off", 32'(busy), 32'd0);
        chk("t2_lines_off", 32'(lines), 32'd0);
        chk("t2_step", step_cnt, 32'd5);

        // T3 loop, restart directly from DONE, stop after 12 cycles
        begin_run(4'd2, 1'b1);
        chk("t3_done_clr", 32'(done), 32'd0);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            chk("t3_lines", 32'(lines), 32'(pat_lines[i % 5]));
            chk("t3_pc", 32'(pc), 32'(pat_pc[i % 5]));
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t3_busy_off", 32'(busy), 32'd0);
        chk("t3_lines_off", 32'(lines), 32'd0);
        chk("t3_obs_off", 32'(obs), 32'd0);
        chk("t3_pc_off", 32'(pc), 32'd0);
        chk("t3_done_off", 32'(done), 32'd0);
        tick();
        chk("t3_step_hold", step_cnt, 32'd12);

        // T4 write during RUN is rejected
        begin_run(4'd2, 1'b0);
        chk("t4_err_idle", 32'(load_err), 32'd0);
        load(4'd1, 7'h7C);
        chk("t4_err_pulse", 32'(load_err), 32'd1);
        tick();
        chk("t4_err_clear", 32'(load_err), 32'd0);
        for (int i = 0; i < 20 && !done; i++) tick();
        chk("t4_done", 32'(done), 32'd1);
        begin_run(4'd2, 1'b0);
        tick();
        chk("t4_old_lines", 32'(lines), 32'd2);
        chk("t4_old_obs", 32'(obs), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Write in the same cycle as start reaches entry 0
        load_en   = 1'b1;
        load_addr = 4'd0;
        load_data = 7'h02;
        last_addr = 4'd0;
        loop_mode = 1'b0;
        start     = 1'b1;
        tick();
        load_en = 1'b0;
        start   = 1'b0;
        chk("byp_lines", 32'(lines), 32'd2);
        chk("byp_err", 32'(load_err), 32'd0);
        tick();
        chk("byp_done", 32'(done), 32'd1);
        chk("byp_step", step_cnt, 32'd1);

        // T5 start and stop together: stop wins
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t5_done_to_idle", 32'(done), 32'd0);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        tick();
        chk("t5_busy_later", 32'(busy), 32'd0);
        chk("t5_lines", 32'(lines), 32'd0);

        // T6 maximum hold of 16 cycles
        load(4'd0, 7'h7F);
        begin_run(4'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) tick();
            chk("t6_lines", 32'(lines), 32'd3);
            chk("t6_busy", 32'(busy), 32'd1);
        end
        tick();
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_step", step_cnt, 32'd16);
        chk("t6_lines_off", 32'(lines), 32'd0);

        // T1 asynchronous reset mid-run, between clock edges
        begin_run(4'd0, 1'b1);
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("t1_lines", 32'(lines), 32'd0);
        chk("t1_obs", 32'(obs), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_done", 32'(done), 32'd0);
        chk("t1_pc", 32'(pc), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_idle_lines", 32'(lines), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
